// File: rtl/nv_nvdla_intr_pkg.sv
// Shared constants and types for the layer-done interrupt generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nv_nvdla_intr_pkg;

   // Default width of the outstanding-write counter and per-entry remain counters
   localparam int OS_CNT_W_DFLT = 8;

   // Number of layers that may wait for their writes to drain at once
   localparam int QUEUE_DEPTH = 2;

   // One pending layer: which register group it belongs to and how many of
   // the writes issued before its layer_done are still in flight.
   typedef struct packed {
      logic                     vld;
      logic                     grp;
      logic [OS_CNT_W_DFLT-1:0] remain;
   } done_entry_t;

   // Done pulse encoding towards the global interrupt controller
   function automatic logic [1:0] grp_onehot(input logic grp);
      return grp ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/nv_nvdla_done_intr_queue.sv
// Two-entry in-order queue of layers waiting for their writes to complete.
// Latency: pop is decided in the cycle the head's remain count reaches zero.
// Backpressure: a push into a full queue with no same-cycle pop is refused.
module nv_nvdla_done_intr_queue
   import nv_nvdla_intr_pkg::*;
#(
   parameter int OS_CNT_W = OS_CNT_W_DFLT
)
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_push,
   input  logic                i_push_grp,
   input  logic [OS_CNT_W-1:0] i_push_remain,
   input  logic                i_cmpl,
   output logic                o_accept,
   output logic                o_pop,
   output logic                o_pop_grp,
   output logic                o_any_vld
);

   // Same layout as done_entry_t, sized by this instance's counter width
   typedef struct packed {
      logic                vld;
      logic                grp;
      logic [OS_CNT_W-1:0] remain;
   } entry_t;

   entry_t r_q   [QUEUE_DEPTH];
   entry_t w_dec [QUEUE_DEPTH];
   entry_t w_sh  [QUEUE_DEPTH];
   entry_t w_nxt [QUEUE_DEPTH];
   entry_t w_new;
   logic   w_full;

   // Entries stay compacted towards slot 0, so slot 0 is always the oldest.
   // A completion retires one write from every entry still waiting on one;
   // the head pops as soon as its post-decrement count is zero.
   always_comb begin
      w_new    = '{vld: 1'b1, grp: i_push_grp, remain: i_push_remain};
      w_full   = r_q[0].vld && r_q[1].vld;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
         w_dec[i] = r_q[i];
         if (i_cmpl && r_q[i].vld && (r_q[i].remain != '0))
            w_dec[i].remain = r_q[i].remain - OS_CNT_W'(1);
      end
      o_pop     = w_dec[0].vld && (w_dec[0].remain == '0);
      o_pop_grp = w_dec[0].grp;
      o_accept  = i_push && (!w_full || o_pop);
      o_any_vld = r_q[0].vld || r_q[1].vld;
      if (o_pop) begin
         w_sh[0] = w_dec[1];
         w_sh[1] = '0;
      end else begin
         w_sh[0] = w_dec[0];
         w_sh[1] = w_dec[1];
      end
      // The pushed entry's count already includes this cycle's completion,
      // so it is inserted after the decrement, not before.
      w_nxt[0] = w_sh[0];
      w_nxt[1] = w_sh[1];
      if (o_accept) begin
         if (!w_sh[0].vld) w_nxt[0] = w_new;
         else              w_nxt[1] = w_new;
      end
   end

   // Queue storage
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q[0] <= '0;
         r_q[1] <= '0;
      end else begin
         r_q[0] <= w_nxt[0];
         r_q[1] <= w_nxt[1];
      end
   end

endmodule

// File: rtl/nv_nvdla_done_intr_gen.sv
// Raises a per-group done pulse once all writes issued before layer_done have completed.
// Latency: 2 cycles from layer_done with nothing in flight; else 1 cycle after the last completion.
// Backpressure: none; a layer_done arriving with both slots busy is dropped and flagged in err.
module nv_nvdla_done_intr_gen
   import nv_nvdla_intr_pkg::*;
#(
   parameter int OS_CNT_W = OS_CNT_W_DFLT
)
(
   input  logic       nvdla_core_clk,
   input  logic       nvdla_core_rstn,
   input  logic       layer_done,
   input  logic       wr_issue,
   input  logic       wr_cmpl,
   output logic [1:0] done_intr_pd,
   output logic       intr_ptr,
   output logic       busy,
   output logic       err
);

   logic [OS_CNT_W-1:0] r_os_cnt;
   logic [OS_CNT_W-1:0] w_os_next;
   logic                w_ovf;
   logic                w_udf;
   logic                w_accept;
   logic                w_pop;
   logic                w_pop_grp;
   logic                w_any_vld;
   logic                w_overrun;
   logic                r_intr_ptr;
   logic                r_err;
   logic [1:0]          r_done_pd;

   // Outstanding-write count: saturates at all-ones and holds at zero
   always_comb begin
      w_os_next = r_os_cnt;
      w_ovf     = 1'b0;
      w_udf     = 1'b0;
      if (wr_issue && !wr_cmpl) begin
         if (r_os_cnt == '1) w_ovf     = 1'b1;
         else                w_os_next = r_os_cnt + OS_CNT_W'(1);
      end else if (wr_cmpl && !wr_issue) begin
         if (r_os_cnt == '0) w_udf     = 1'b1;
         else                w_os_next = r_os_cnt - OS_CNT_W'(1);
      end
   end

   nv_nvdla_done_intr_queue #(
      .OS_CNT_W (OS_CNT_W)
   ) u_queue (
      .i_clk         (nvdla_core_clk),
      .i_rst_n       (nvdla_core_rstn),
      .i_push        (layer_done),
      .i_push_grp    (r_intr_ptr),
      .i_push_remain (w_os_next),
      .i_cmpl        (wr_cmpl),
      .o_accept      (w_accept),
      .o_pop         (w_pop),
      .o_pop_grp     (w_pop_grp),
      .o_any_vld     (w_any_vld)
   );

   assign w_overrun = layer_done && !w_accept;

   // Counter, group pointer, sticky error and registered done pulse
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_os_cnt   <= '0;
         r_intr_ptr <= 1'b0;
         r_err      <= 1'b0;
         r_done_pd  <= 2'b00;
      end else begin
         r_os_cnt  <= w_os_next;
         r_done_pd <= w_pop ? grp_onehot(w_pop_grp) : 2'b00;
         if (w_accept)
            r_intr_ptr <= ~r_intr_ptr;
         if (w_ovf || w_udf || w_overrun)
            r_err <= 1'b1;
      end
   end

   assign done_intr_pd = r_done_pd;
   assign intr_ptr     = r_intr_ptr;
   assign err          = r_err;
   assign busy         = w_any_vld || (r_os_cnt != '0);

endmodule

// File: tb/tb_nv_nvdla_done_intr_gen.sv
// Self-checking bench: expected done pulses are queued with their due cycle and matched by a monitor.
// Latency: n/a.
// Backpressure: n/a.
module tb_nv_nvdla_done_intr_gen;

   logic       clk;
   logic       rstn;
   logic       layer_done;
   logic       wr_issue;
   logic       wr_cmpl;
   logic [1:0] done_intr_pd;
   logic       intr_ptr;
   logic       busy;
   logic       err;

   typedef struct {
      int         cyc;
      logic [1:0] val;
   } exp_t;

   exp_t       sb[$];
   int         cyc    = 0;
   int         n_chk  = 0;
   int         n_pass = 0;
   logic [1:0] mon_exp;

   nv_nvdla_done_intr_gen #(.OS_CNT_W(8)) dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rstn),
      .layer_done      (layer_done),
      .wr_issue        (wr_issue),
      .wr_cmpl         (wr_cmpl),
      .done_intr_pd    (done_intr_pd),
      .intr_ptr        (intr_ptr),
      .busy            (busy),
      .err             (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic expect_pd(input int at, input logic [1:0] val);
      exp_t e;
      e.cyc = at;
      e.val = val;
      sb.push_back(e);
   endtask

   // Inputs change on the falling edge and are captured by the next rising edge
   task automatic step(input logic ld, input logic iss, input logic cm);
      @(negedge clk);
      layer_done = ld;
      wr_issue   = iss;
      wr_cmpl    = cm;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn       = 1'b0;
      layer_done = 1'b0;
      wr_issue   = 1'b0;
      wr_cmpl    = 1'b0;
      #1;
      chk("rst_pd",   {30'd0, done_intr_pd}, 32'd0);
      chk("rst_ptr",  {31'd0, intr_ptr},     32'd0);
      chk("rst_busy", {31'd0, busy},         32'd0);
      chk("rst_err",  {31'd0, err},          32'd0);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Every nonzero observed pulse, and every pulse due this cycle, is compared
   always @(negedge clk) begin
      if (rstn) begin
         mon_exp = 2'b00;
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_exp = sb[0].val;
            void'(sb.pop_front());
         end
         if (mon_exp != 2'b00 || done_intr_pd != 2'b00)
            chk("done_pd", {30'd0, done_intr_pd}, {30'd0, mon_exp});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn       = 1'b0;
      layer_done = 1'b0;
      wr_issue   = 1'b0;
      wr_cmpl    = 1'b0;
      do_reset();

      // Layer done with nothing in flight: pulse two cycles later, pointer flips
      step(1, 0, 0);
      expect_pd(cyc + 2, 2'b01);
      step(0, 0, 0);
      chk("a_ptr", {31'd0, intr_ptr}, 32'd1);
      idle(4);
      chk("a_busy", {31'd0, busy}, 32'd0);
      chk("a_err",  {31'd0, err},  32'd0);

      // Three writes drain after layer_done
      do_reset();
      repeat (3) step(0, 1, 0);
      step(1, 0, 0);
      idle(2);
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 0, 1);
      expect_pd(cyc + 1, 2'b01);
      chk("b_busy_hi", {31'd0, busy}, 32'd1);
      step(0, 0, 0);
      chk("b_busy_lo", {31'd0, busy}, 32'd0);
      idle(3);

      // Two groups with different drain points
      do_reset();
      step(0, 1, 0);
      step(0, 1, 0);
      step(1, 0, 0);
      step(0, 1, 0);
      step(1, 0, 0);
      idle(1);
      step(0, 0, 1);
      step(0, 0, 1);
      expect_pd(cyc + 1, 2'b01);
      step(0, 0, 1);
      expect_pd(cyc + 1, 2'b10);
      idle(4);
      chk("c_ptr", {31'd0, intr_ptr}, 32'd0);

      // Back-to-back layer_done, push and pop in the same cycle
      do_reset();
      step(1, 0, 0);
      expect_pd(cyc + 2, 2'b01);
      step(1, 0, 0);
      expect_pd(cyc + 2, 2'b10);
      idle(4);
      chk("d_err", {31'd0, err}, 32'd0);

      // Third layer_done while full is dropped; both entries drain on one completion
      do_reset();
      step(0, 1, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      chk("e_err_pre", {31'd0, err}, 32'd0);
      step(0, 0, 0);
      chk("e_err",  {31'd0, err},      32'd1);
      chk("e_ptr",  {31'd0, intr_ptr}, 32'd0);
      step(0, 0, 1);
      expect_pd(cyc + 1, 2'b01);
      expect_pd(cyc + 2, 2'b10);
      idle(5);
      chk("e_busy", {31'd0, busy}, 32'd0);

      // Completion with nothing outstanding: error, counter held at zero
      do_reset();
      step(0, 0, 1);
      step(0, 0, 0);
      chk("f_err",  {31'd0, err},  32'd1);
      chk("f_busy", {31'd0, busy}, 32'd0);
      step(1, 0, 0);
      expect_pd(cyc + 2, 2'b01);
      idle(4);

      // Reset with one pending entry: nothing emitted afterwards
      do_reset();
      step(0, 1, 0);
      step(1, 0, 0);
      step(0, 0, 0);
      chk("g_busy_hi", {31'd0, busy}, 32'd1);
      do_reset();
      idle(6);
      chk("g_busy_lo", {31'd0, busy},     32'd0);
      chk("g_ptr",     {31'd0, intr_ptr}, 32'd0);

      // Counter saturates at 255 on the 256th issue
      do_reset();
      repeat (255) step(0, 1, 0);
      step(0, 1, 0);
      chk("h_err_pre", {31'd0, err}, 32'd0);
      step(0, 0, 0);
      chk("h_err", {31'd0, err}, 32'd1);
      step(1, 0, 0);
      repeat (254) step(0, 0, 1);
      chk("h_busy_hi", {31'd0, busy}, 32'd1);
      step(0, 0, 1);
      expect_pd(cyc + 1, 2'b01);
      idle(4);
      chk("h_busy_lo", {31'd0, busy}, 32'd0);

      chk("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
